// File: rtl/instr_sequencer.sv
// Instruction sequencer: presents a stored program on IR, one word every CPI cycles.
// Optional macro INSTR_SEQUENCER_LOOP_EN wraps the last entry back to address 0.
module instr_sequencer #(
  parameter int unsigned IR_W    = 32,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned CPI     = 5,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic                     CLK,
  input  logic                     RST_F,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [IR_W-1:0]          ld_data,
  input  logic                     start,
  input  logic                     abort,
  output logic [IR_W-1:0]          IR,
  output logic                     ir_valid,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic                     busy,
  output logic                     done,
  output logic                     halted
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [7:0]  CntLoad = 8'(CPI - 1);
  localparam logic [AW-1:0] PcLast = AW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state;
  logic [IR_W-1:0] r_ir;
  logic [AW-1:0]   r_pc;
  logic [7:0]      r_cnt;
  logic            r_ir_valid;
  logic            r_halted;
  logic [IR_W-1:0] r_mem [DEPTH];

  logic            w_wr;
  logic [IR_W-1:0] w_mem0;
  logic [AW-1:0]   w_pc_nxt;
  logic            w_is_halt;

  assign w_wr      = ld_en && !abort && (r_state != StRun);
  // Same-cycle write to entry 0 must be what start issues.
  assign w_mem0    = (w_wr && (ld_addr == '0)) ? ld_data : r_mem[0];
  assign w_pc_nxt  = r_pc + AW'(1);
  assign w_is_halt = (r_ir[IR_W-1 -: 4] == HALT_OP);

  // Program store is deliberately outside the reset domain.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      r_state    <= StIdle;
      r_ir       <= '0;
      r_pc       <= '0;
      r_cnt      <= '0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_ir_valid <= 1'b0;
      if (abort) begin
        r_state  <= StIdle;
        r_ir     <= '0;
        r_pc     <= '0;
        r_cnt    <= '0;
        r_halted <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle, StDone: begin
            if (start) begin
              r_state    <= StRun;
              r_ir       <= w_mem0;
              r_pc       <= '0;
              r_cnt      <= CntLoad;
              r_ir_valid <= 1'b1;
              r_halted   <= 1'b0;
            end
          end
          StRun: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - 8'd1;
            end else if (w_is_halt) begin
              r_state  <= StDone;
              r_halted <= 1'b1;
            end else if (r_pc != PcLast) begin
              r_pc       <= w_pc_nxt;
              r_ir       <= r_mem[w_pc_nxt];
              r_cnt      <= CntLoad;
              r_ir_valid <= 1'b1;
            end else begin
`ifdef INSTR_SEQUENCER_LOOP_EN
              r_pc       <= '0;
              r_ir       <= r_mem[0];
              r_cnt      <= CntLoad;
              r_ir_valid <= 1'b1;
`else
              r_state <= StDone;
`endif
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign IR       = r_ir;
  assign pc       = r_pc;
  assign ir_valid = r_ir_valid;
  assign halted   = r_halted;
  assign busy     = (r_state == StRun);
  assign done     = (r_state == StDone);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed vector table, corner sequences and
// randomized programs checked against a timing-arithmetic reference model.
module tb_instr_sequencer;

`ifdef INSTR_SEQUENCER_LOOP_EN
  localparam bit Loop = 1'b1;
`else
  localparam bit Loop = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_F = 1'b1;

  logic        a_ld_en = 0, a_start = 0, a_abort = 0;
  logic [3:0]  a_ld_addr = '0;
  logic [31:0] a_ld_data = '0;
  logic [31:0] a_ir;
  logic [3:0]  a_pc;
  logic        a_vld, a_busy, a_done, a_halted;

  logic        b_ld_en = 0, b_start = 0, b_abort = 0;
  logic [1:0]  b_ld_addr = '0;
  logic [31:0] b_ld_data = '0;
  logic [31:0] b_ir;
  logic [1:0]  b_pc;
  logic        b_vld, b_busy, b_done, b_halted;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];

  always #5 CLK = ~CLK;

  instr_sequencer u_dut (
    .CLK(CLK), .RST_F(RST_F), .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data),
    .start(a_start), .abort(a_abort), .IR(a_ir), .ir_valid(a_vld), .pc(a_pc),
    .busy(a_busy), .done(a_done), .halted(a_halted)
  );

  instr_sequencer #(.DEPTH(4), .CPI(1)) u_dut4 (
    .CLK(CLK), .RST_F(RST_F), .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data),
    .start(b_start), .abort(b_abort), .IR(b_ir), .ir_valid(b_vld), .pc(b_pc),
    .busy(b_busy), .done(b_done), .halted(b_halted)
  );

  typedef struct packed {
    logic [31:0] ir;
    logic        vld;
    logic [3:0]  pc;
    logic        bsy;
    logic        dn;
    logic        hlt;
  } exp_t;

  typedef struct {
    int   cyc;
    exp_t e;
  } vec_t;

  // Expected outputs n cycles after start, from issue times alone: word k appears at
  // cycle 1 + k*c; the run stops after the first halt word (or the last entry).
  function automatic exp_t model(input logic [31:0] m [16], input int d, input int c,
                                 input int n);
    exp_t e;
    int   h = -1;
    int   k;
    int   last;
    for (int i = 0; i < d; i++) if (h < 0 && m[i][31:28] == 4'hF) h = i;
    k     = (n - 1) / c;
    e.vld = ((n - 1) % c == 0);
    e.dn  = 1'b0;
    e.hlt = 1'b0;
    e.bsy = 1'b1;
    if (Loop && h < 0) begin
      e.pc = 4'(k % d);
      e.ir = m[k % d];
    end else begin
      last = (h < 0) ? d - 1 : h;
      if (k <= last) begin
        e.pc = 4'(k);
        e.ir = m[k];
      end else begin
        e.pc  = 4'(last);
        e.ir  = m[last];
        e.vld = 1'b0;
        e.bsy = 1'b0;
        e.dn  = 1'b1;
        e.hlt = (h >= 0);
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int n, input exp_t e, input logic [31:0] ir,
                         input logic v, input logic [3:0] p, input logic b, input logic d,
                         input logic h);
    chk($sformatf("%s_ir@%0d", tag, n), ir, e.ir);
    chk($sformatf("%s_vld@%0d", tag, n), {31'd0, v}, {31'd0, e.vld});
    chk($sformatf("%s_pc@%0d", tag, n), {28'd0, p}, {28'd0, e.pc});
    chk($sformatf("%s_busy@%0d", tag, n), {31'd0, b}, {31'd0, e.bsy});
    chk($sformatf("%s_done@%0d", tag, n), {31'd0, d}, {31'd0, e.dn});
    chk($sformatf("%s_halt@%0d", tag, n), {31'd0, h}, {31'd0, e.hlt});
  endtask

  task automatic load_a(input int addr, input logic [31:0] data);
    a_ld_en   = 1'b1;
    a_ld_addr = 4'(addr);
    a_ld_data = data;
    tick();
    a_ld_en   = 1'b0;
    mem_a[addr] = data;
  endtask

  task automatic abort_a();
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
  endtask

  vec_t vecs [11];

  initial begin
    int          n;
    int          cnt;
    int          run_len;
    logic [3:0]  op;
    logic [31:0] w;
    exp_t        e;

    vecs[0]  = '{1,  '{32'h00000000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0}};
    vecs[1]  = '{2,  '{32'h00000000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0}};
    vecs[2]  = '{5,  '{32'h00000000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0}};
    vecs[3]  = '{6,  '{32'h8801000A, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0}};
    vecs[4]  = '{10, '{32'h8801000A, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0}};
    vecs[5]  = '{11, '{32'h88020007, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0}};
    vecs[6]  = '{16, '{32'h80213002, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0}};
    vecs[7]  = '{21, '{32'hF0000000, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0}};
    vecs[8]  = '{25, '{32'hF0000000, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0}};
    vecs[9]  = '{26, '{32'hF0000000, 1'b0, 4'd4, 1'b0, 1'b1, 1'b1}};
    vecs[10] = '{27, '{32'hF0000000, 1'b0, 4'd4, 1'b0, 1'b1, 1'b1}};

    // Asynchronous reset before any clock edge.
    #2 RST_F = 1'b0;
    #1;
    chk_all("reset", 0, '{32'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0},
            a_ir, a_vld, a_pc, a_busy, a_done, a_halted);
    repeat (2) @(negedge CLK);
    RST_F = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) load_a(i, 32'h0);
    load_a(1, 32'h8801000A);
    load_a(2, 32'h88020007);
    load_a(3, 32'h80213002);
    load_a(4, 32'hF0000000);

    // Reference program run, directed vector table.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    n = 1;
    for (int v = 0; v < 11; v++) begin
      while (n < vecs[v].cyc) begin
        tick();
        n++;
      end
      chk_all("vec", n, vecs[v].e, a_ir, a_vld, a_pc, a_busy, a_done, a_halted);
    end

    // Restart from DONE, abort at cycle 13.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (n = 1; n < 13; n++) tick();
    chk("abort_pre_ir", a_ir, 32'h88020007);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk_all("abort", 14, '{32'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0},
            a_ir, a_vld, a_pc, a_busy, a_done, a_halted);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_vld) cnt++;
    end
    chk("abort_no_valid", cnt, 0);

    // start and abort together in IDLE.
    a_start = 1'b1;
    a_abort = 1'b1;
    tick();
    a_start = 1'b0;
    a_abort = 1'b0;
    chk("start_abort_busy", {31'd0, a_busy}, 32'd0);
    chk("start_abort_vld", {31'd0, a_vld}, 32'd0);

    // Write during RUN is dropped; reset mid-run clears outputs asynchronously.
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
    a_ld_en   = 1'b1;
    a_ld_addr = 4'd1;
    a_ld_data = 32'hDEADBEEF;
    tick();
    a_ld_en = 1'b0;
    for (n = 4; n < 8; n++) tick();
    #2 RST_F = 1'b0;
    #1;
    chk_all("midreset", 8, '{32'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0},
            a_ir, a_vld, a_pc, a_busy, a_done, a_halted);
    @(negedge CLK);
    RST_F = 1'b1;
    tick();
    chk("post_reset_vld", {31'd0, a_vld}, 32'd0);
    chk("post_reset_busy", {31'd0, a_busy}, 32'd0);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (n = 1; n < 6; n++) tick();
    chk("prog_kept_ir", a_ir, 32'h8801000A);
    abort_a();

    // Write to address 0 in the same cycle as start is what gets issued.
    a_ld_en   = 1'b1;
    a_ld_addr = 4'd0;
    a_ld_data = 32'h12345678;
    a_start   = 1'b1;
    tick();
    a_ld_en = 1'b0;
    a_start = 1'b0;
    mem_a[0] = 32'h12345678;
    chk("wr_first_ir", a_ir, 32'h12345678);
    chk("wr_first_vld", {31'd0, a_vld}, 32'd1);
    abort_a();

    // Randomized programs against the model, with ignored writes sprinkled in RUN.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        op = (($urandom % 8) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        w  = $urandom;
        load_a(i, {op, w[27:0]});
      end
      run_len = $urandom_range(10, 100);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (n = 1; n <= run_len; n++) begin
        e = model(mem_a, 16, 5, n);
        chk_all("rand", n, e, a_ir, a_vld, a_pc, a_busy, a_done, a_halted);
        a_ld_en = e.bsy && (($urandom % 8) == 0);
        a_ld_addr = 4'($urandom);
        a_ld_data = $urandom;
        if (n < run_len) tick();
      end
      a_ld_en = 1'b0;
      abort_a();
      chk("rand_abort_ir", a_ir, 32'h0);
    end

    // DEPTH=4, CPI=1 instance, no halt word.
    for (int i = 0; i < 16; i++) mem_b[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      b_ld_en   = 1'b1;
      b_ld_addr = 2'(i);
      b_ld_data = 32'h10000000 + 32'(i);
      tick();
      mem_b[i] = b_ld_data;
    end
    b_ld_en = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (n = 1; n <= 8; n++) begin
      e = model(mem_b, 4, 1, n);
      chk_all("d4", n, e, b_ir, b_vld, {2'b00, b_pc}, b_busy, b_done, b_halted);
      if (n == 5) begin
`ifdef INSTR_SEQUENCER_LOOP_EN
        chk("d4_wrap_pc", {30'd0, b_pc}, 32'd0);
        chk("d4_wrap_busy", {31'd0, b_busy}, 32'd1);
`else
        chk("d4_end_done", {31'd0, b_done}, 32'd1);
        chk("d4_end_pc", {30'd0, b_pc}, 32'd3);
`endif
      end
      tick();
    end
    b_abort = 1'b1;
    tick();
    b_abort = 1'b0;
    chk("d4_abort_busy", {31'd0, b_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
